// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Shift-and-add multiply sequencer driving the shared ALU buses.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int         WIDTH  = 16,
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SHR = 3'b010,
    parameter logic [2:0] OP_SHL = 3'b011,
    parameter logic [2:0] OP_DIR = 3'b110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TEST = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        alu_op   = OP_DIR;
        alu_a    = '0;
        alu_b    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    state_d  = S_TEST;
                end
            end
            S_TEST: begin
                if (mplier_q == '0)
                    state_d = S_DONE;
                else if (mplier_q[0])
                    state_d = S_ADD;
                else
                    state_d = S_SHL;
            end
            S_ADD: begin
                alu_op  = OP_ADD;
                alu_a   = acc_q;
                alu_b   = mcand_q;
                acc_d   = alu_out;
                state_d = S_SHL;
            end
            S_SHL: begin
                alu_op  = OP_SHL;
                alu_a   = mcand_q;
                alu_b   = C_ONE;
                mcand_d = alu_out;
                state_d = S_SHR;
            end
            S_SHR: begin
                alu_op   = OP_SHR;
                alu_a    = mplier_q;
                alu_b    = C_ONE;
                mplier_d = alu_out;
                // The shifted multiplier is tested straight off the ALU output.
                if (alu_out == '0)
                    state_d = S_DONE;
                else if (alu_out[0])
                    state_d = S_ADD;
                else
                    state_d = S_SHL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // acc is stable in TEST and SHR, so capturing it on entry to DONE is exact.
        if ((state_d == S_DONE) && (state_q != S_DONE))
            result_d = acc_q;
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign alu_own = busy;
    assign result  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Brief    : Directed self-checking bench for alu_mul_seq with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    localparam int         WIDTH  = 16;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_DIR = 3'b110;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [34:0] ops [$];
    int          last_cyc;

    alu_mul_seq #(
        .WIDTH  (WIDTH),
        .OP_ADD (OP_ADD),
        .OP_SHR (OP_SHR),
        .OP_SHL (OP_SHL),
        .OP_DIR (OP_DIR)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .alu_own (alu_own),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU model
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_SHR:  alu_out = alu_a >> alu_b;
            OP_SHL:  alu_out = alu_a << alu_b;
            OP_DIR:  alu_out = alu_a;
            default: alu_out = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse and follows the operation to its done pulse.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input int exp_cyc);
        int cyc;
        ops.delete();
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        chk({tag, " busy c1"}, {63'd0, busy}, 64'd1);
        chk({tag, " alu_own c1"}, {63'd0, alu_own}, 64'd1);
        while (done !== 1'b1 && cyc < 200) begin
            if (alu_op !== OP_DIR)
                ops.push_back({alu_op, alu_a, alu_b});
            tick();
            cyc++;
        end
        last_cyc = cyc;
        chk({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " result"}, {48'd0, result}, {48'd0, exp_res});
        tick();
        chk({tag, " busy after"}, {63'd0, busy}, 64'd0);
        chk({tag, " done after"}, {63'd0, done}, 64'd0);
        chk({tag, " alu_own after"}, {63'd0, alu_own}, 64'd0);
        chk({tag, " result held"}, {48'd0, result}, {48'd0, exp_res});
    endtask

    initial begin
        logic [34:0] exp1 [6];
        int          cyc;

        exp1[0] = {OP_ADD, 16'd0,  16'd5};
        exp1[1] = {OP_SHL, 16'd5,  16'd1};
        exp1[2] = {OP_SHR, 16'd3,  16'd1};
        exp1[3] = {OP_ADD, 16'd5,  16'd10};
        exp1[4] = {OP_SHL, 16'd10, 16'd1};
        exp1[5] = {OP_SHR, 16'd1,  16'd1};

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        chk("rst busy",    {63'd0, busy},    64'd0);
        chk("rst done",    {63'd0, done},    64'd0);
        chk("rst alu_own", {63'd0, alu_own}, 64'd0);
        chk("rst result",  {48'd0, result},  64'd0);
        chk("rst alu_op",  {61'd0, alu_op},  {61'd0, OP_DIR});
        chk("rst alu_a",   {48'd0, alu_a},   64'd0);
        chk("rst alu_b",   {48'd0, alu_b},   64'd0);
        rst = 1'b0;
        tick();

        // 5 * 3: two ADD/SHL/SHR rounds
        do_op("5x3", 16'd5, 16'd3, 16'd15, 8);
        chk("5x3 op count", 64'(ops.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < ops.size())
                chk($sformatf("5x3 uop%0d", i), {29'd0, ops[i]}, {29'd0, exp1[i]});

        // Zero multiplier: straight TEST -> DONE
        do_op("x0", 16'h1234, 16'h0000, 16'h0000, 2);
        chk("x0 op count", 64'(ops.size()), 64'd0);

        // Worst-case latency and truncation
        do_op("ffff2", 16'hFFFF, 16'hFFFF, 16'h0001, 50);

        // Held start: operands changed during busy must not disturb op 1
        op_a  = 16'd7;
        op_b  = 16'h8000;
        start = 1'b1;
        tick();
        cyc  = 1;
        op_a = 16'd3;
        op_b = 16'd4;
        chk("hold busy c1", {63'd0, busy}, 64'd1);
        chk("hold result pre", {48'd0, result}, 64'h1);
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("hold done cycle", 64'(cyc), 64'd35);
        chk("hold result1", {48'd0, result}, 64'h8000);
        tick();
        chk("hold gap idle", {63'd0, busy}, 64'd0);
        chk("hold gap result", {48'd0, result}, 64'h8000);
        tick();
        chk("hold op2 busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("hold op2 done cycle", 64'(cyc), 64'd9);
        chk("hold result2", {48'd0, result}, 64'd12);
        tick();
        tick();

        // Reset mid-operation
        op_a  = 16'd9;
        op_b  = 16'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst busy c4", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy",   {63'd0, busy},   64'd0);
        chk("midrst done",   {63'd0, done},   64'd0);
        chk("midrst result", {48'd0, result}, 64'd0);
        chk("midrst alu_op", {61'd0, alu_op}, {61'd0, OP_DIR});
        tick();
        chk("midrst still idle", {63'd0, busy}, 64'd0);

        do_op("2x2", 16'd2, 16'd2, 16'd4, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
